pdm_mic_ctrl: RTL
=================

# pdm_mic_ctrl

Controller that sequences the CIC3 PDM decimator and its microphone. It generates the PDM microphone clock from the system clock and samples the PDM data pin on a selectable phase. It feeds the decimator with clock-enable strobes and discards the decimator's settling outputs. Valid PCM samples are buffered in a small FIFO that the peripheral register interface reads.

## Interface
- DIV_WIDTH, 8: width of the clock-divider setting.
- FIFO_DEPTH, 4: PCM FIFO entries; power of two, ≥2.
- SETTLE_SAMPLES, 3: decimator outputs discarded after each start; 0 means no discard.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  level; 1 = run microphone and capture.
- clk_div  in  DIV_WIDTH  PDM half-period is max(clk_div,1)+1 clk cycles.
- edge_sel  in  1  0 = sample data at pdm_clk_out falling edge; 1 = sample at rising edge.
- pdm_clk_out  out  1  clock to the microphone.
- pdm_data_in  in  1  PDM data pin, already synchronised.
- cic_rst  out  1  decimator reset.
- cic_ce  out  1  one-cycle strobe: decimator consumes cic_bit.
- cic_bit  out  1  sampled PDM bit.
- cic_pcm  in  16  decimator output (signed).
- cic_valid  in  1  one-cycle strobe: cic_pcm is new.
- rd_en  in  1  pop request.
- rd_data  out  16  FIFO head; valid when rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- ovf  out  1  sticky overflow flag.
- clr_ovf  in  1  clears ovf.

## Operation
- The FSM has four states: IDLE, START, SETTLE and RUN.
- **IDLE:** pdm_clk_out=0, divider counter=0, cic_rst=1, cic_ce=0. When enable=1, go to START.
- **START (exactly 1 cycle):**
  - cic_rst=1.
  - FIFO flushed (count→0); ovf unchanged.
  - Settle counter cleared.
  - Next state is SETTLE, or RUN if SETTLE_SAMPLES=0.
- **SETTLE / RUN:** cic_rst=0 and the divider runs.
  - In SETTLE, each cic_valid increments the settle counter. When it reaches SETTLE_SAMPLES, go to RUN; that sample is also discarded.
  - In RUN, each cic_valid pushes cic_pcm into the FIFO.
- enable=0 in any state goes to IDLE on the next edge. FIFO contents are kept and remain readable.
- **Divider:**
  - The counter increments every cycle while running.
  - When counter ≥ max(clk_div,1): toggle pdm_clk_out and reset the counter to 0. The ≥ compare makes a mid-run decrease of clk_div take effect without a wrap.
  - The first toggle after START is rising.
- **Sampling:**
  - At the clk edge where pdm_clk_out toggles to the phase selected by edge_sel: cic_bit←pdm_data_in and cic_ce←1.
  - cic_ce is high exactly one cycle.
  - The result is one strobe per PDM period.
- **FIFO:**
  - Push when full: the sample is dropped and ovf←1.
  - Pop when empty: ignored.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **ovf:** clr_ovf clears it. If clr_ovf and a new overflow occur in the same cycle, set wins.

## Timing
- Reset values:
  - pdm_clk_out=0, cic_rst=1, cic_ce=0, cic_bit=0.
  - rd_valid=0, fifo_count=0, ovf=0, rd_data=0.
  - FSM in IDLE.
- Async reset mid-operation returns everything to the reset values immediately; FIFO contents are lost.
- enable rising edge, counting the edge that samples enable=1 as edge 0:
  - START occupies the cycle after edge 0.
  - The divider starts counting at edge 2.
  - The first rising edge of pdm_clk_out follows max(clk_div,1) further cycles.
- A push is registered on the edge that samples cic_valid=1. rd_valid and fifo_count update in the following cycle.
- rd_data is combinational from the head entry. After a pop the new head is visible the next cycle.
- After enable falls, pdm_clk_out=0 and cic_rst=1 from the next cycle.
- A cic_valid arriving in the same cycle as enable falling is still processed.

## Test plan
- Divider and sampling:
  - Stimulus: clk_div=3, edge_sel=0, enable=1, pdm_data_in toggling.
  - Required: pdm_clk_out period of 8 clk; cic_ce once per 8 cycles, aligned to each falling edge; cic_bit equals pdm_data_in at that edge.
  - Repeat with edge_sel=1: strobes move to the rising edges.
- Settling:
  - Stimulus: a bench decimator model pulses cic_valid with values 1, 2, 3, 4, 5.
  - Required: the FIFO receives only 4 and 5; fifo_count=2; rd_data=4.
- Overflow:
  - Stimulus: in RUN, push 10, 11, 12, 13, 14 with no reads.
  - Required: fifo_count=4, ovf=1, pops return 10, 11, 12, 13; clr_ovf→ovf=0.
- Full-FIFO simultaneous push and pop:
  - Stimulus: FIFO full with 10–13; rd_en high together with cic_valid carrying 20.
  - Required: count stays 4, ovf stays 0, later pops return 11, 12, 13, 20.
- Disable and re-enable:
  - Stimulus: enable=0 mid-run with 2 samples buffered.
  - Required: next cycle pdm_clk_out=0 and cic_rst=1; the 2 samples are still poppable.
  - Stimulus: re-enable.
  - Required: one-cycle cic_rst pulse; FIFO flushed to count=0.
- Async reset:
  - Stimulus: rst asserted between clk edges while in RUN.
  - Required: all outputs take their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone sequencer: clocks the mic, strobes the CIC3 decimator,
// drops its settling outputs and buffers valid PCM in a small FIFO.
module pdm_mic_ctrl #(
  parameter int DIV_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [DIV_WIDTH-1:0]            clk_div,
  input  logic                            edge_sel,
  output logic                            pdm_clk_out,
  input  logic                            pdm_data_in,
  output logic                            cic_rst,
  output logic                            cic_ce,
  output logic                            cic_bit,
  input  logic [15:0]                     cic_pcm,
  input  logic                            cic_valid,
  input  logic                            rd_en,
  output logic [15:0]                     rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            ovf,
  input  logic                            clr_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES+1) : 1;

  typedef enum logic [1:0] {IDLE, START, SETTLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [SW-1:0]        settle_cnt;
  logic                 settle_last;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_lim;
  logic                 running;
  logic [15:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 full, push_req, push, pop, ovf_set;

  assign settle_last = (int'(settle_cnt) >= SETTLE_SAMPLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = START;
      START:   state_nxt = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      SETTLE:  if (cic_valid && settle_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  assign cic_rst = (state == IDLE) || (state == START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                settle_cnt <= '0;
    else if (state == START)                settle_cnt <= '0;
    else if (state == SETTLE && cic_valid)  settle_cnt <= settle_cnt + SW'(1);
  end

  // Divider stops the same edge enable is seen low so the mic clock parks at 0.
  assign running = enable && (state == SETTLE || state == RUN);
  assign div_lim = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      pdm_clk_out <= 1'b0;
      cic_ce      <= 1'b0;
      cic_bit     <= 1'b0;
    end else begin
      cic_ce <= 1'b0;
      if (!running) begin
        div_cnt     <= '0;
        pdm_clk_out <= 1'b0;
      end else if (div_cnt >= div_lim) begin
        div_cnt     <= '0;
        pdm_clk_out <= ~pdm_clk_out;
        if ((~pdm_clk_out) == edge_sel) begin
          cic_bit <= pdm_data_in;
          cic_ce  <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
    end
  end

  // A full FIFO still accepts a push when a pop frees the head in the same cycle.
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign push_req = cic_valid && (state == RUN);
  assign pop      = rd_en && (fifo_count != '0);
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (state == START) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cic_pcm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 16'h0000;

endmodule
